arbitro_display: RTL and testbench

ARBITRO_DISPLAY -- requirements
Module: arbitro_display

---
 rtl/arbitro_display_pkg.sv | 47 ++++
 rtl/arbitro_display_temporizador_refresh.sv | 44 ++++
 rtl/arbitro_display.sv | 166 ++++++++++++++++
 tb/tb_arbitro_display.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arbitro_display_pkg.sv
// Shared definitions for the display arbiter: FSM states, arbitration
// bookkeeping, the six window-setup command bytes and default sizing.
package arbitro_display_pkg;

    localparam int FRAME_BYTES_DEFAULT = 1024;
    localparam int REFRESH_DIV_DEFAULT = 400000;

    // Column range 0..127 followed by page range 0..7
    localparam int         WIN_BYTES     = 6;
    localparam logic [7:0] WIN_COL_CMD   = 8'h21;
    localparam logic [7:0] WIN_COL_START = 8'h00;
    localparam logic [7:0] WIN_COL_END   = 8'h7F;
    localparam logic [7:0] WIN_PAGE_CMD  = 8'h22;
    localparam logic [7:0] WIN_PAGE_STRT = 8'h00;
    localparam logic [7:0] WIN_PAGE_END  = 8'h07;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD_SEND,
        ST_WIN_SEND,
        ST_FETCH,
        ST_DATA_SEND,
        ST_DONE
    } state_t;

    // Which requester was served last; used to alternate on ties
    typedef enum logic {
        SERVED_FRAME = 1'b0,
        SERVED_CMD   = 1'b1
    } served_t;

    // Window-setup byte for a given position in the 6-byte sequence
    function automatic logic [7:0] winByte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = WIN_COL_CMD;
            3'd1:    b = WIN_COL_START;
            3'd2:    b = WIN_COL_END;
            3'd3:    b = WIN_PAGE_CMD;
            3'd4:    b = WIN_PAGE_STRT;
            3'd5:    b = WIN_PAGE_END;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/arbitro_display_temporizador_refresh.sv
// Auto-refresh timer: free-running counter that raises a sticky refresh
// flag every REFRESH_DIV cycles. The flag is cleared once a frame finishes.
// Only exists when ARBITRO_DISPLAY_AUTO_REFRESH_EN is defined.
`ifdef ARBITRO_DISPLAY_AUTO_REFRESH_EN
module temporizador_refresh
    import arbitro_display_pkg::*;
#(
    parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_flag
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [CW-1:0] r_count;
    logic          r_flag;
    logic          w_tick;

    assign w_tick = (r_count == CW'(REFRESH_DIV - 1));
    assign o_flag = r_flag;

    // Period counter and sticky flag; a new tick wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_flag  <= 1'b0;
        end else begin
            if (w_tick) begin
                r_count <= '0;
                r_flag  <= 1'b1;
            end else begin
                r_count <= r_count + 1'b1;
                if (i_clear) begin
                    r_flag <= 1'b0;
                end
            end
        end
    end

endmodule
`endif

// File: rtl/arbitro_display.sv
// Display bus arbiter: shares one SPI byte serializer between a command
// requester and an image controller streaming full frames. Frames are
// preceded by a 6-byte window setup and never interleaved with commands.
// Optional feature macro: ARBITRO_DISPLAY_AUTO_REFRESH_EN (periodic frame
// refresh via temporizador_refresh).
module arbitro_display
    import arbitro_display_pkg::*;
#(
    parameter int FRAME_BYTES = FRAME_BYTES_DEFAULT,
    parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_req,
    input  logic       cmd_req,
    input  logic [7:0] cmd_byte,
    input  logic [7:0] frame_data,
    output logic [9:0] byte_counter,
    output logic [7:0] spi_data,
    output logic       spi_valid,
    output logic       spi_dc,
    input  logic       spi_ready,
    output logic       cmd_grant,
    output logic       frame_done,
    output logic       busy
);

    localparam logic [2:0] WIN_LAST = 3'(WIN_BYTES - 1);

    state_t     r_state;
    state_t     w_nextState;
    logic [2:0] r_winIdx;
    logic [9:0] r_byteCounter;
    logic [7:0] r_pixel;
    served_t    r_lastServed;
    logic       w_framePending;
    logic       w_lastByte;

    assign w_lastByte   = (r_byteCounter == 10'(FRAME_BYTES - 1));
    assign byte_counter = r_byteCounter;

`ifdef ARBITRO_DISPLAY_AUTO_REFRESH_EN
    logic w_refreshFlag;
    logic w_refreshClear;

    assign w_refreshClear = (r_state == ST_DONE);

    temporizador_refresh #(
        .REFRESH_DIV(REFRESH_DIV)
    ) u_temporizador (
        .clk    (clk),
        .rst    (rst),
        .i_clear(w_refreshClear),
        .o_flag (w_refreshFlag)
    );

    assign w_framePending = frame_req | w_refreshFlag;
`else
    assign w_framePending = frame_req;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode and per-state drive of the serializer interface
    always_comb begin
        w_nextState = r_state;
        spi_data    = 8'h00;
        spi_valid   = 1'b0;
        spi_dc      = 1'b0;
        cmd_grant   = 1'b0;
        frame_done  = 1'b0;
        busy        = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (cmd_req && ((r_lastServed == SERVED_FRAME) || !w_framePending)) begin
                    w_nextState = ST_CMD_SEND;
                end else if (w_framePending) begin
                    w_nextState = ST_WIN_SEND;
                end
            end
            ST_CMD_SEND: begin
                spi_data  = cmd_byte;
                spi_valid = 1'b1;
                if (spi_ready) begin
                    cmd_grant   = 1'b1;
                    w_nextState = ST_IDLE;
                end
            end
            ST_WIN_SEND: begin
                spi_data  = winByte(r_winIdx);
                spi_valid = 1'b1;
                if (spi_ready && (r_winIdx == WIN_LAST)) begin
                    w_nextState = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_nextState = ST_DATA_SEND;
            end
            ST_DATA_SEND: begin
                spi_data  = r_pixel;
                spi_dc    = 1'b1;
                spi_valid = 1'b1;
                if (spi_ready) begin
                    w_nextState = w_lastByte ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE: begin
                frame_done  = 1'b1;
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Window index, frame address, captured pixel and tie-break memory
    always_ff @(posedge clk) begin
        if (rst) begin
            r_winIdx      <= 3'd0;
            r_byteCounter <= 10'd0;
            r_pixel       <= 8'h00;
            r_lastServed  <= SERVED_FRAME;
        end else begin
            case (r_state)
                ST_CMD_SEND: begin
                    if (spi_ready) begin
                        r_lastServed <= SERVED_CMD;
                    end
                end
                ST_WIN_SEND: begin
                    if (spi_ready) begin
                        if (r_winIdx == WIN_LAST) begin
                            r_winIdx      <= 3'd0;
                            r_byteCounter <= 10'd0;
                        end else begin
                            r_winIdx <= r_winIdx + 3'd1;
                        end
                    end
                end
                ST_FETCH: begin
                    r_pixel <= frame_data;
                end
                ST_DATA_SEND: begin
                    if (spi_ready && !w_lastByte) begin
                        r_byteCounter <= r_byteCounter + 10'd1;
                    end
                end
                ST_DONE: begin
                    r_byteCounter <= 10'd0;
                    r_lastServed  <= SERVED_FRAME;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_display.sv
// Testbench for arbitro_display with a 4-byte frame. The reference model
// predicts the accepted byte stream (dc flag + data) and the order of
// cmd_grant / frame_done events from the protocol rules alone.
module tb_arbitro_display;

    localparam int FB   = 4;
    localparam int RDIV = 50;

    localparam logic [7:0] WIN [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_req;
    logic       cmd_req;
    logic [7:0] cmd_byte;
    logic [7:0] frame_data;
    logic [9:0] byte_counter;
    logic [7:0] spi_data;
    logic       spi_valid;
    logic       spi_dc;
    logic       spi_ready;
    logic       cmd_grant;
    logic       frame_done;
    logic       busy;

    logic [7:0] mem [FB];
    logic [8:0] acc [$];
    logic [8:0] exq [$];
    logic [7:0] ev  [$];
    int errors = 0;
    int checks = 0;

    arbitro_display #(
        .FRAME_BYTES(FB),
        .REFRESH_DIV(RDIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_req   (frame_req),
        .cmd_req     (cmd_req),
        .cmd_byte    (cmd_byte),
        .frame_data  (frame_data),
        .byte_counter(byte_counter),
        .spi_data    (spi_data),
        .spi_valid   (spi_valid),
        .spi_dc      (spi_dc),
        .spi_ready   (spi_ready),
        .cmd_grant   (cmd_grant),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Image controller: pixel byte selected by the requested address
    always_comb begin
        frame_data = 8'h00;
        if (int'(byte_counter) < FB) begin
            frame_data = mem[int'(byte_counter)];
        end
    end

    // Monitor: a byte shown with valid&ready at the falling edge is taken
    // at the next rising edge (inputs only change just after rising edges)
    always @(negedge clk) begin
        if (!rst) begin
            if (spi_valid && spi_ready) acc.push_back({spi_dc, spi_data});
            if (cmd_grant) ev.push_back("C");
            if (frame_done) ev.push_back("F");
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void expectFrame();
        for (int i = 0; i < 6; i++) exq.push_back({1'b0, WIN[i]});
        for (int i = 0; i < FB; i++) exq.push_back({1'b1, mem[i]});
    endfunction

    function automatic void clearModel();
        acc.delete();
        exq.delete();
        ev.delete();
    endfunction

    task automatic doReset();
        rst = 1'b1;
        frame_req = 1'b0;
        cmd_req = 1'b0;
        spi_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks++; if (spi_valid !== 1'b0)      begin errors++; $display("[TB] FAIL reset_valid got=%b want=0", spi_valid); end
        checks++; if (busy !== 1'b0)           begin errors++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        checks++; if (byte_counter !== 10'd0)  begin errors++; $display("[TB] FAIL reset_bc got=%0d want=0", byte_counter); end
        checks++; if (spi_data !== 8'h00)      begin errors++; $display("[TB] FAIL reset_data got=%h want=00", spi_data); end
        checks++; if (spi_dc !== 1'b0)         begin errors++; $display("[TB] FAIL reset_dc got=%b want=0", spi_dc); end
        checks++; if ({cmd_grant, frame_done} !== 2'b00) begin errors++; $display("[TB] FAIL reset_pulses got=%b want=00", {cmd_grant, frame_done}); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_cmd(input logic [7:0] b);
        int n;
        clearModel();
        exq.push_back({1'b0, b});
        cmd_byte = b;
        cmd_req = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cmd_grant && n < 20) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (!cmd_grant) begin
            errors++; $display("[TB] FAIL cmd_timeout got=no_grant want=grant");
        end else begin
            checks++; if (spi_data !== b)  begin errors++; $display("[TB] FAIL cmd_data got=%h want=%h", spi_data, b); end
            checks++; if (spi_dc !== 1'b0) begin errors++; $display("[TB] FAIL cmd_dc got=%b want=0", spi_dc); end
        end
        @(posedge clk);
        #1;
        cmd_req = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL cmd_busy_after got=%b want=0", busy); end
        tick();
        checks++;
        if (acc.size() != exq.size()) begin
            errors++; $display("[TB] FAIL cmd_len got=%0d want=%0d", acc.size(), exq.size());
        end else if (acc[0] !== exq[0]) begin
            errors++; $display("[TB] FAIL cmd_stream got=%h want=%h", acc[0], exq[0]);
        end
        checks++; if (ev.size() != 1) begin errors++; $display("[TB] FAIL cmd_grant_count got=%0d want=1", ev.size()); end
    endtask

    task automatic test_frame(input bit ramp, input bit stall);
        int n;
        bit seen;
        for (int i = 0; i < FB; i++) mem[i] = ramp ? 8'(i + 8'h10) : 8'($urandom);
        clearModel();
        expectFrame();
        frame_req = 1'b1;
        n = 0;
        seen = 0;
        while (!seen && n < 400) begin
            @(negedge clk);
            n++;
            seen = frame_done;
            if (!seen) begin
                @(posedge clk);
                #1;
                if (stall) spi_ready = ($urandom_range(0, 3) != 0);
            end
        end
        @(posedge clk);
        #1;
        frame_req = 1'b0;
        spi_ready = 1'b1;
        tick();
        checks++; if (!seen) begin errors++; $display("[TB] FAIL frame_timeout got=no_done want=done"); end
        if (!stall) begin
            checks++; if (n != 6 + 2 * FB + 2) begin errors++; $display("[TB] FAIL frame_cycles got=%0d want=%0d", n, 6 + 2 * FB + 2); end
        end
        checks++;
        if (acc.size() != exq.size()) begin
            errors++; $display("[TB] FAIL frame_len got=%0d want=%0d", acc.size(), exq.size());
        end else begin
            foreach (exq[i]) begin
                checks++;
                if (acc[i] !== exq[i]) begin errors++; $display("[TB] FAIL frame_byte%0d got=%h want=%h", i, acc[i], exq[i]); end
            end
        end
        checks++; if (ev.size() != 1) begin errors++; $display("[TB] FAIL frame_done_count got=%0d want=1", ev.size()); end
    endtask

    task automatic test_stall();
        int n;
        for (int i = 0; i < FB; i++) mem[i] = 8'($urandom);
        clearModel();
        expectFrame();
        frame_req = 1'b1;
        n = 0;
        @(negedge clk);
        while (!(spi_valid && spi_dc && byte_counter == 10'd1) && n < 40) begin
            n++;
            @(negedge clk);
        end
        checks++; if (n >= 40) begin errors++; $display("[TB] FAIL stall_reach got=timeout want=byte1"); end
        @(posedge clk);
        #1;
        spi_ready = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({spi_valid, spi_dc, spi_data, byte_counter} !== {1'b1, 1'b1, mem[2], 10'd2}) begin
                errors++;
                $display("[TB] FAIL stall_hold%0d got=v%b dc%b %h bc%0d want=v1 dc1 %h bc2", k, spi_valid, spi_dc, spi_data, byte_counter, mem[2]);
            end
        end
        @(posedge clk);
        #1;
        spi_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!frame_done && n < 40) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        frame_req = 1'b0;
        tick();
        checks++;
        if (acc.size() != exq.size()) begin
            errors++; $display("[TB] FAIL stall_len got=%0d want=%0d", acc.size(), exq.size());
        end else begin
            foreach (exq[i]) begin
                checks++;
                if (acc[i] !== exq[i]) begin errors++; $display("[TB] FAIL stall_byte%0d got=%h want=%h", i, acc[i], exq[i]); end
            end
        end
        checks++; if (ev.size() != 1) begin errors++; $display("[TB] FAIL stall_done_count got=%0d want=1", ev.size()); end
    endtask

    task automatic test_arbitration();
        int n;
        int fCount;
        logic [7:0] b;
        doReset();
        b = 8'($urandom);
        for (int i = 0; i < FB; i++) mem[i] = 8'($urandom);
        clearModel();
        exq.push_back({1'b0, b});
        expectFrame();
        exq.push_back({1'b0, b});
        expectFrame();
        cmd_byte = b;
        cmd_req = 1'b1;
        frame_req = 1'b1;
        n = 0;
        fCount = 0;
        while (fCount < 2 && n < 200) begin
            @(negedge clk);
            n++;
            if (frame_done) fCount++;
        end
        @(posedge clk);
        #1;
        cmd_req = 1'b0;
        frame_req = 1'b0;
        tick();
        tick();
        checks++; if (fCount != 2) begin errors++; $display("[TB] FAIL arb_timeout got=%0d want=2", fCount); end
        checks++;
        if (ev.size() != 4) begin
            errors++; $display("[TB] FAIL arb_event_count got=%0d want=4", ev.size());
        end else if ({ev[0], ev[1], ev[2], ev[3]} !== "CFCF") begin
            errors++; $display("[TB] FAIL arb_order got=%s want=CFCF", {ev[0], ev[1], ev[2], ev[3]});
        end
        checks++;
        if (acc.size() != exq.size()) begin
            errors++; $display("[TB] FAIL arb_len got=%0d want=%0d", acc.size(), exq.size());
        end else begin
            foreach (exq[i]) begin
                checks++;
                if (acc[i] !== exq[i]) begin errors++; $display("[TB] FAIL arb_byte%0d got=%h want=%h", i, acc[i], exq[i]); end
            end
        end
    endtask

    task automatic test_reset_midframe();
        int n;
        for (int i = 0; i < FB; i++) mem[i] = 8'($urandom);
        clearModel();
        frame_req = 1'b1;
        n = 0;
        @(negedge clk);
        while (!(spi_valid && spi_dc && byte_counter == 10'd2) && n < 40) begin
            n++;
            @(negedge clk);
        end
        checks++; if (n >= 40) begin errors++; $display("[TB] FAIL rstmid_reach got=timeout want=byte2"); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        frame_req = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if ({spi_valid, spi_dc, spi_data, byte_counter, cmd_grant, frame_done, busy} !== 23'd0) begin
            errors++;
            $display("[TB] FAIL rstmid_outputs got=v%b dc%b %h bc%0d g%b d%b b%b want=all_zero", spi_valid, spi_dc, spi_data, byte_counter, cmd_grant, frame_done, busy);
        end
        tick();
        rst = 1'b0;
        tick();
        tick();
        checks++; if (ev.size() != 0) begin errors++; $display("[TB] FAIL rstmid_no_done got=%0d want=0", ev.size()); end
        clearModel();
        expectFrame();
        frame_req = 1'b1;
        n = 0;
        @(negedge clk);
        while (!frame_done && n < 40) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        frame_req = 1'b0;
        tick();
        checks++;
        if (acc.size() == 0 || acc[0] !== {1'b0, 8'h21}) begin
            errors++; $display("[TB] FAIL rstmid_restart got=%h want=021", (acc.size() == 0) ? 9'h000 : acc[0]);
        end
        checks++;
        if (acc.size() != exq.size()) begin
            errors++; $display("[TB] FAIL rstmid_len got=%0d want=%0d", acc.size(), exq.size());
        end else begin
            foreach (exq[i]) begin
                checks++;
                if (acc[i] !== exq[i]) begin errors++; $display("[TB] FAIL rstmid_byte%0d got=%h want=%h", i, acc[i], exq[i]); end
            end
        end
    endtask

`ifdef ARBITRO_DISPLAY_AUTO_REFRESH_EN
    task automatic test_auto_refresh();
        int rises [$];
        logic prevBusy;
        doReset();
        prevBusy = 1'b0;
        for (int n = 1; n <= 130; n++) begin
            @(negedge clk);
            if (busy && !prevBusy) rises.push_back(n);
            prevBusy = busy;
        end
        checks++;
        if (rises.size() < 2) begin
            errors++; $display("[TB] FAIL refresh_count got=%0d want>=2", rises.size());
        end else begin
            checks++; if (rises[0] != RDIV + 2) begin errors++; $display("[TB] FAIL refresh_first got=%0d want=%0d", rises[0], RDIV + 2); end
            checks++; if (rises[1] - rises[0] != RDIV) begin errors++; $display("[TB] FAIL refresh_period got=%0d want=%0d", rises[1] - rises[0], RDIV); end
        end
    endtask
`else
    task automatic test_no_traffic();
        int activity;
        doReset();
        activity = 0;
        for (int n = 0; n < 120; n++) begin
            @(negedge clk);
            if (busy || spi_valid) activity++;
        end
        checks++; if (activity != 0) begin errors++; $display("[TB] FAIL no_traffic got=%0d want=0", activity); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        frame_req = 1'b0;
        cmd_req = 1'b0;
        cmd_byte = 8'h00;
        spi_ready = 1'b1;
        for (int i = 0; i < FB; i++) mem[i] = 8'h00;
        test_reset();
`ifdef ARBITRO_DISPLAY_AUTO_REFRESH_EN
        test_auto_refresh();
`else
        test_cmd(8'hAF);
        for (int k = 0; k < 3; k++) test_cmd(8'($urandom));
        test_frame(1'b1, 1'b0);
        test_frame(1'b0, 1'b0);
        for (int k = 0; k < 3; k++) test_frame(1'b0, 1'b1);
        test_stall();
        test_arbitration();
        test_reset_midframe();
        test_no_traffic();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
